// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes and default busy lengths.
// Optional feature macro: MDU_MADD_EN adds the accumulate ops (madd, maddu, msub and msubu).
package mdu_pkg;

  // MDUOp encoding driven by the decoder.
  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8,
    OpMadd  = 4'd9,
    OpMaddu = 4'd10,
    OpMsub  = 4'd11,
    OpMsubu = 4'd12
  } mdu_op_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with the architectural HI/LO registers.
// Long ops (mult/multu/div/divu, plus madd/maddu/msub/msubu when MDU_MADD_EN is defined) latch
// their operands on the accepting edge. They then hold busy for a fixed count and write HI/LO on
// the edge where busy falls. mthi/mtlo write at once. mfhi/mflo read through MDUresult.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   A, B           forwarded rs/rt operands
//   MDUOp, start   operation code, qualified by start
//   busy           multi-cycle operation in progress
//   MDUresult      HI for mfhi, LO for mflo, otherwise 0
//   HI, LO         architectural registers
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] MDUresult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CntW = 16;
  // A zero count would never retire, so the shortest op is one cycle.
  localparam int unsigned MultLoad = (MULT_CYCLES == 0) ? 1 : MULT_CYCLES;
  localparam int unsigned DivLoad  = (DIV_CYCLES == 0) ? 1 : DIV_CYCLES;

  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  mdu_op_e         op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // Datapath on the latched operands
  logic [63:0] prod_s, prod_u;
  logic        b_zero, div_ovf;
  logic [31:0] div_b;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    b_zero  = (b_q == 32'd0);
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    // Keep the divider away from /0 and INT_MIN/-1; both cases are resolved below.
    div_b = (b_zero || div_ovf) ? 32'd1 : b_q;
    quo_u = a_q / div_b;
    rem_u = a_q % div_b;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(a_q) / $signed(div_b);
      rem_s = $signed(a_q) % $signed(div_b);
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      // Any start while busy is dropped.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        case (op_q)
          OpMult:  {hi_d, lo_d} = prod_s;
          OpMultu: {hi_d, lo_d} = prod_u;
          OpDiv:   if (!b_zero) {hi_d, lo_d} = {rem_s, quo_s};
          OpDivu:  if (!b_zero) {hi_d, lo_d} = {rem_u, quo_u};
`ifdef MDU_MADD_EN
          OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
          OpMsub:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          OpMsubu: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
          default: ;
        endcase
      end
    end else if (start) begin
      case (mdu_op_e'(MDUOp))
`ifdef MDU_MADD_EN
        OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
`else
        OpMult, OpMultu: begin
`endif
          a_d    = A;
          b_d    = B;
          op_d   = mdu_op_e'(MDUOp);
          cnt_d  = CntW'(MultLoad);
          busy_d = 1'b1;
        end
        OpDiv, OpDivu: begin
          a_d    = A;
          b_d    = B;
          op_d   = mdu_op_e'(MDUOp);
          cnt_d  = CntW'(DivLoad);
          busy_d = 1'b1;
        end
        OpMthi:  hi_d = A;
        OpMtlo:  lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OpNone;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    MDUresult = '0;
    case (mdu_op_e'(MDUOp))
      OpMfhi:  MDUresult = hi_q;
      OpMflo:  MDUresult = lo_q;
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  MDUOp = 4'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] MDUresult, HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .MDUOp     (MDUOp),
    .start     (start),
    .busy      (busy),
    .MDUresult (MDUresult),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
  endtask

  task automatic expect_op(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                           input int cycles);
    exp_t e;
    e.tag = tag;
    e.hi = hi;
    e.lo = lo;
    e.cycles = cycles;
    sb.push_back(e);
  endtask

  // Counts busy samples (one per negedge), then retires the oldest expectation.
  task automatic wait_done(input int prior);
    int   cyc;
    exp_t e;
    cyc = prior;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    assert (sb.size() > 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_busy_cycles"}, 64'(cyc), 64'(e.cycles));
      check({e.tag, "_hi"}, {32'b0, HI}, {32'b0, e.hi});
      check({e.tag, "_lo"}, {32'b0, LO}, {32'b0, e.lo});
    end
  endtask

  initial begin
    // Reset
    #12;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_hi", {32'b0, HI}, 64'd0);
    check("reset_lo", {32'b0, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // mult -3 * 7
    expect_op("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    issue(OpMult, 32'hFFFF_FFFD, 32'd7);
    wait_done(0);

    // divu 100 / 7
    expect_op("divu", 32'd2, 32'd14, 10);
    issue(OpDivu, 32'd100, 32'd7);
    wait_done(0);

    // div -7 / 2
    expect_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done(0);

    // mthi/mtlo preload, no busy
    issue(OpMthi, 32'd1, 32'd0);
    check("mthi_no_busy", {63'b0, busy}, 64'd0);
    issue(OpMtlo, 32'd2, 32'd0);
    check("mtlo_no_busy", {63'b0, busy}, 64'd0);
    check("mthi_hi", {32'b0, HI}, 64'd1);
    check("mtlo_lo", {32'b0, LO}, 64'd2);

    // Divide by zero leaves HI/LO untouched
    expect_op("div_zero", 32'd1, 32'd2, 10);
    issue(OpDiv, 32'd55, 32'd0);
    wait_done(0);
    MDUOp = OpMfhi;
    #1 check("mfhi_result", {32'b0, MDUresult}, 64'd1);
    MDUOp = OpMflo;
    #1 check("mflo_result", {32'b0, MDUresult}, 64'd2);
    MDUOp = OpMult;
    #1 check("result_other_op", {32'b0, MDUresult}, 64'd0);
    MDUOp = 4'd0;
    @(negedge clk);

    // Signed overflow case
    expect_op("div_ovf", 32'd0, 32'h8000_0000, 10);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0);

    // multu max * max
    expect_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);

    // Start during busy is ignored; operand changes have no effect
    expect_op("div_ignore", 32'd2, 32'hFFFF_FFF0, 10);
    issue(OpDiv, 32'd50, 32'hFFFF_FFFD);
    MDUOp = OpMult;
    A     = 32'd5;
    B     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    MDUOp = OpMthi;
    A     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    MDUOp = 4'd0;
    B     = 32'd9;
    wait_done(2);

    // Reset in busy cycle 3 of multu aborts the op
    issue(OpMultu, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", {63'b0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, HI}, 64'd0);
    check("abort_lo", {32'b0, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_write_hi", {32'b0, HI}, 64'd0);
    check("abort_no_write_lo", {32'b0, LO}, 64'd0);
    check("abort_no_busy", {63'b0, busy}, 64'd0);

    // First op after reset
    expect_op("mult_after_reset", 32'd0, 32'd42, 5);
    issue(OpMult, 32'd6, 32'd7);
    wait_done(0);

    // Reserved code 13 is a no-op
    issue(4'd13, 32'd9, 32'd9);
    check("code13_no_busy", {63'b0, busy}, 64'd0);
    check("code13_lo", {32'b0, LO}, 64'd42);

    // madd from zero
    issue(OpMthi, 32'd0, 32'd0);
    issue(OpMtlo, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
    expect_op("madd", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(OpMadd, 32'hFFFF_FFFF, 32'd2);
    wait_done(0);
    expect_op("maddu", 32'h0000_0001, 32'hFFFF_FFFC, 5);
    issue(OpMaddu, 32'hFFFF_FFFF, 32'd2);
    wait_done(0);
`else
    issue(OpMadd, 32'hFFFF_FFFF, 32'd2);
    check("madd_off_busy", {63'b0, busy}, 64'd0);
    repeat (6) @(negedge clk);
    check("madd_off_hi", {32'b0, HI}, 64'd0);
    check("madd_off_lo", {32'b0, LO}, 64'd0);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL take parameter MULT_CYCLES, default 5: busy length in cycles for mult/multu (and madd family).
REQ-002 The block SHALL take parameter DIV_CYCLES, default 10: busy length in cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port A, input, 32 bits: forwarded rs operand, the same EX-stage operand that feeds the ALU.
REQ-006 The block SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-007 The block SHALL have port MDUOp, input, 4 bits: operation code.
REQ-008 The block SHALL have port start, input, 1 bit: EX-stage instruction valid, qualifies MDUOp.
REQ-009 The block SHALL have port busy, output, 1 bit: multi-cycle operation in progress.
REQ-010 The block SHALL have port MDUresult, output, 32 bits: mfhi/mflo read data to the EX result mux.
REQ-011 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-012 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-013 MDUOp codes SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9-15 are handled per REQ-030/031.
REQ-014 A start=1 with mult/multu/div/divu while busy=0 SHALL latch A, B and the op, and load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-015 Busy SHALL be registered, rising the cycle after the accepting edge and staying high for exactly the loaded count.
REQ-016 HI/LO SHALL update on the edge where the counter reaches zero, so new values are visible in the same cycle busy first reads 0.
REQ-017 mult SHALL write {HI,LO} = signed 64-bit A*B; multu SHALL write the unsigned 64-bit product.
REQ-018 div SHALL write LO = signed quotient truncated toward zero and HI = remainder carrying the dividend's sign; divu SHALL produce the unsigned quotient and remainder.
REQ-019 Division with B=0 SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-020 Signed div of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give LO=32'h8000_0000 and HI=0.
REQ-021 start with mthi/mtlo while busy=0 SHALL write A into HI/LO at that edge, with no busy.
REQ-022 MDUresult SHALL be HI for mfhi and LO for mflo, combinationally from MDUOp, and 0 for all other codes.
REQ-023 start with any op while busy=1 SHALL be ignored; the pipeline stalls on (start & MDU op) | busy, and the block does not rely on that stall.
REQ-024 Latched operands SHALL be used for the computation; A/B changes during busy SHALL have no effect.
REQ-025 start=0 SHALL cause no state change apart from counter progression.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear HI, LO, counter, busy and latched operands to 0, including mid-operation, aborting any pending result.
REQ-027 After rst_n rises, the first accepting edge SHALL behave per REQ-014.

Configuration
REQ-028 Macro MDU_MADD_EN SHALL compile in the accumulate ops.
REQ-029 With MDU_MADD_EN, codes 9 madd, 10 maddu, 11 msub and 12 msubu SHALL use MULT_CYCLES and write {HI,LO} = {HI,LO} ± product (signed/unsigned), mod 2^64.
REQ-030 Without MDU_MADD_EN, codes 9-12 SHALL be treated as none: no busy, no write.
REQ-031 Codes 13-15 SHALL always be treated as none.

Structure
REQ-032 MDUOp code defines and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared definitions header alongside the ALUOp defines.
REQ-033 The block SHALL be a single module with counter and datapath inline; no sub-module.

Verification
REQ-034 The bench SHALL check: mult A=-3, B=7 -> busy high 5 cycles, then HI=FFFF_FFFF, LO=FFFF_FFEB.
REQ-035 The bench SHALL check: divu A=100, B=7 -> busy high 10 cycles, then LO=14, HI=2; div A=-7, B=2 -> LO=-3, HI=-1.
REQ-036 The bench SHALL check: div by B=0 with HI=1, LO=2 preloaded via mthi/mtlo -> 10 busy cycles, then HI=1, LO=2; mfhi -> MDUresult=1.
REQ-037 The bench SHALL check: start mult during busy from a prior div -> ignored, final HI/LO equal to the div result only.
REQ-038 The bench SHALL check: rst_n pulsed low in busy cycle 3 of multu -> busy=0 and HI=LO=0 immediately, with no later write.
REQ-039 The bench SHALL check, with MDU_MADD_EN: {HI,LO}=0 then madd 0xFFFF_FFFF x 2 -> HI=FFFF_FFFF, LO=FFFF_FFFE; without the macro, the same op leaves 0.
